dmem_port_arbiter: RTL and testbench

//  Shares the single-port 64-bit data memory between two requesters: port 0 (core load/store unit) and port 1 (program loader/debug).

---
 rtl/dmem_arb_pkg.sv | 6 +
 rtl/rr_arb2.sv | 12 +
 rtl/dmem_port_arbiter.sv | 78 +++++++
 tb/tb_dmem_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;
  localparam int NUM_PORTS = 2;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} arb_state_t;
  typedef logic port_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, the port that did not win last time wins a tie
// valid[1:0] request per port, last_grant previous winner, grant[1:0] one-hot winner or 0
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  port_id_t             last_grant,
  output logic [NUM_PORTS-1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of a single-port 64-bit data memory between two requesters
// Ports: clk, rst (sync, active-low); req_valid/req_ready/req_we per port, req{0,1}_addr/wdata;
//   rsp_valid per port, rsp_rdata, rsp_err; mem_wrt_en/mem_address/mem_write_data to memory,
//   mem_read_data combinational from memory.
// Build option: DMEM_RANGE_CHECK_EN enables the alignment/range error check.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [NUM_PORTS-1:0] req_we,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req0_wdata,
  input  logic [DATA_W-1:0]    req1_wdata,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_wrt_en,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_write_data,
  input  logic [DATA_W-1:0]    mem_read_data
);
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  arb_state_t             state, nxt;
  port_id_t               last_grant, lat_port;
  logic                   lat_we, err;
  logic [ADDR_W-1:0]      lat_addr;
  logic [DATA_W-1:0]      lat_wdata;
  logic [NUM_PORTS-1:0]   grant;
  rr_arb2 u_arb (.valid(req_valid), .last_grant(last_grant), .grant(grant));
  // With the check disabled this folds to 0 and the address passes through unchecked.
  assign err = RANGE_CHK && (|lat_addr[2:0] || lat_addr > ADDR_W'(MEM_BYTES - 8));
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;
  // Outputs are gated by rst so a reset cycle never writes memory or responds.
  always_comb begin
    nxt        = state == S_IDLE ? (|grant ? S_ACCESS : S_IDLE) : state == S_ACCESS ? S_RESP : S_IDLE;
    req_ready  = (rst && state == S_IDLE) ? grant : '0;
    mem_wrt_en = rst && state == S_ACCESS && lat_we && !err;
    rsp_valid  = (rst && state == S_RESP) ? NUM_PORTS'(1) << lat_port : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && |grant) begin
        last_grant <= grant[1];
        lat_port   <= grant[1];
        lat_we     <= grant[1] ? req_we[1] : req_we[0];
        lat_addr   <= grant[1] ? req1_addr : req0_addr;
        lat_wdata  <= grant[1] ? req1_wdata : req0_wdata;
      end
      if (state == S_ACCESS) begin
        rsp_rdata <= (lat_we || err) ? '0 : mem_read_data;
        rsp_err   <= err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized and directed check of dmem_port_arbiter against a transaction-level model
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [63:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
  logic [63:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        rsp_err, mem_wrt_en;
  int          checks = 0, errors = 0;
  dmem_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wrt_en(mem_wrt_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;
  // byte-wide little-endian data memory
  logic [7:0] tb_mem [64] = '{default: 8'h00};
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = tb_mem[6'(mem_address[5:0] + 6'(i))];
  end
  always @(posedge clk)
    if (mem_wrt_en)
      for (int i = 0; i < 8; i++) tb_mem[6'(mem_address[5:0] + 6'(i))] <= mem_write_data[8*i +: 8];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic range_err(input logic [63:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a % 8 != 0) || (a > 56);
`else
    return a != a;
`endif
  endfunction
  // model: a doubleword memory plus at most one transaction in flight, timed from its accept cycle
  logic [63:0] ref_mem [8] = '{default: 64'h0};
  logic        lg = 1'b1, pv = 1'b0, pp, pwe, perr, was_rst = 1'b0;
  logic [63:0] pa, pd, pdata;
  logic [1:0]  exp_rdy, exp_rsp;
  logic        exp_wen;
  int          cyc = 0, pt;
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      chk("rst_wen", 64'(mem_wrt_en), 0);
      chk("rst_rsp", 64'(rsp_valid), 0);
      chk("rst_rdy", 64'(req_ready), 0);
      if (was_rst) begin
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 64'(rsp_err), 0);
      end
      pv = 1'b0;
      lg = 1'b1;
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      exp_wen = 1'b0;
      exp_rsp = '0;
      if (pv && cyc == pt + 1) begin
        exp_wen = pwe && !perr;
        chk("acc_addr", mem_address, pa);
        if (exp_wen) chk("acc_wdata", mem_write_data, pd);
        pdata = (pwe || perr) ? 64'h0 : ref_mem[pa[5:3]];
        if (exp_wen) ref_mem[pa[5:3]] = pd;
      end
      if (pv && cyc == pt + 2) begin
        exp_rsp = 2'(1 << pp);
        chk("rsp_rdata", rsp_rdata, pdata);
        chk("rsp_err", 64'(rsp_err), 64'(perr));
      end
      chk("wen", 64'(mem_wrt_en), 64'(exp_wen));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      exp_rdy = pv ? 2'b00 : req_valid == 2'b11 ? (lg ? 2'b01 : 2'b10) : req_valid;
      if (pv && cyc == pt + 2) pv = 1'b0;
      chk("ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != 0) begin
        pv   = 1'b1;
        pp   = exp_rdy[1];
        pwe  = req_we[pp];
        pa   = pp ? req1_addr : req0_addr;
        pd   = pp ? req1_wdata : req0_wdata;
        perr = range_err(pa);
        pt   = cyc;
        lg   = pp;
      end
    end
  end
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [63:0] a0, input logic [63:0] d0,
                       input logic [63:0] a1, input logic [63:0] d1);
    @(negedge clk);
    req_valid = v;
    req_we = we;
    req0_addr = a0;
    req0_wdata = d0;
    req1_addr = a1;
    req1_wdata = d1;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(2'b00, 2'b00, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) drive(2'b11, 2'b00, 64'h00, 0, 64'h18, 0);
    idle(3);
    drive(2'b01, 2'b01, 64'h08, 64'h1122334455667788, 0, 0);
    idle(3);
    drive(2'b10, 2'b00, 0, 0, 64'h08, 0);
    idle(3);
    repeat (7) drive(2'b10, 2'b00, 0, 0, 64'h08, 0);
    idle(3);
    drive(2'b01, 2'b01, 64'h10, 64'hdeadbeefcafef00d, 0, 0);
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    drive(2'b10, 2'b00, 0, 0, 64'h10, 0);
    idle(3);
`ifdef DMEM_RANGE_CHECK_EN
    drive(2'b01, 2'b00, 64'h3c, 0, 0, 0);
    idle(3);
    drive(2'b01, 2'b01, 64'h09, 64'h5555aaaa5555aaaa, 0, 0);
    idle(3);
    drive(2'b01, 2'b00, 64'h38, 0, 0, 0);
    idle(3);
`endif
    repeat (400)
      drive(2'($urandom), 2'($urandom), 64'($urandom_range(0, 7) * 8), {$urandom, $urandom},
            64'($urandom_range(0, 7) * 8), {$urandom, $urandom});
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
